// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder and its storage array.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic MODE_WORD = 1'b0;
  localparam logic MODE_BYTE = 1'b1;

  // Little-endian byte-lane enables: byte mode selects one lane, word mode all four.
  function automatic logic [3:0] lane_en(input logic mode, input logic [1:0] lane);
    if (mode == MODE_BYTE) lane_en = 4'b0001 << lane;
    else lane_en = 4'b1111;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 storage: synchronous write with per-byte-lane enables, combinational read.
// Contents are not reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [3:0]                     we,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, LATENCY wait cycles, response held until resp_ready.
// Optional DMEM_ALIGN_CHECK_EN flags misaligned word and out-of-range accesses via resp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t                state;
  logic [3:0]            cnt;
  logic                  cap_write;
  logic                  cap_mode;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;

  logic                  acc_write;
  logic                  acc_mode;
  logic                  acc_err;
  logic                  do_access;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [DATA_WIDTH-1:0] acc_rdata;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic [3:0]            arr_we;
  logic [7:0]            rd_byte;

  // With LATENCY=0 the access happens in the accept cycle, straight from the request inputs.
  assign acc_write = (state == IDLE) ? req_write : cap_write;
  assign acc_mode  = (state == IDLE) ? req_mode  : cap_mode;
  assign acc_addr  = (state == IDLE) ? req_addr  : cap_addr;
  assign acc_wdata = (state == IDLE) ? req_wdata : cap_wdata;

  assign do_access = ((state == WAIT) && (cnt == 4'd0)) ||
                     ((state == IDLE) && req_valid && req_ready && (LATENCY == 0));

`ifdef DMEM_ALIGN_CHECK_EN
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);

  assign acc_err = ((acc_mode == MODE_WORD) && (acc_addr[1:0] != 2'b00)) ||
                   ({1'b0, acc_addr} >= ADDR_LIMIT);
`else
  logic unused_addr_hi;

  assign acc_err        = 1'b0;
  assign unused_addr_hi = ^acc_addr[ADDR_WIDTH-1:IDX_W+2];
`endif

  // A reset landing on the commit edge must abandon the store.
  assign arr_we    = (do_access && acc_write && !acc_err && !rst) ? lane_en(acc_mode, acc_addr[1:0]) : 4'b0000;
  assign arr_wdata = (acc_mode == MODE_BYTE) ? {4{acc_wdata[7:0]}} : acc_wdata;
  assign rd_byte   = arr_rdata[{acc_addr[1:0], 3'b000} +: 8];

  always_comb begin
    acc_rdata = arr_rdata;
    if (acc_write || acc_err) acc_rdata = '0;
    else if (acc_mode == MODE_BYTE) acc_rdata = {24'd0, rd_byte};
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .idx   (acc_addr[IDX_W+1:2]),
    .we    (arr_we),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      cap_write  <= 1'b0;
      cap_mode   <= MODE_WORD;
      cap_addr   <= '0;
      cap_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cap_write <= req_write;
            cap_mode  <= req_mode;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (LATENCY == 0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= acc_rdata;
              resp_err   <= acc_err;
            end else begin
              state <= WAIT;
              cnt   <= LAT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= acc_rdata;
            resp_err   <= acc_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance (unit 0) and a LATENCY=0 instance (unit 1) share clk/rst.
// Expected responses are queued when a request is issued and checked when the response appears.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int          DEPTH     = 256;
  localparam logic [31:0] WRAP_ADDR = 32'(4 * DEPTH);

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic        req_mode  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        busy       [2];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_mode(req_mode[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .busy(busy[0])
  );

  dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_mode(req_mode[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .busy(busy[1])
  );

  function automatic logic [31:0] pat(input int i);
    pat = {8'(i + 1), 8'hC3, 8'(i * 7), 8'h5A};
  endfunction

  // Presents one request, waits for the accept edge, then scrambles the request inputs
  // and waits for resp_valid. lat counts edges from accept to the first edge that sees resp_valid.
  task automatic do_access(input int u, input logic w, input logic m, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
    int cyc;
    lat = -1;
    req_valid[u] = 1'b1; req_write[u] = w; req_mode[u] = m; req_addr[u] = a; req_wdata[u] = wd;
    cyc = 0;
    while (req_ready[u] !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    req_valid[u] = 1'b0; req_write[u] = ~w; req_addr[u] = $urandom; req_wdata[u] = $urandom;
    cyc = 0;
    while (resp_valid[u] !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    if (resp_valid[u] === 1'b1) lat = cyc + 1;
    rd = resp_rdata[u];
    er = resp_err[u];
  endtask

  task automatic release_resp(input int u);
    resp_ready[u] = 1'b1;
    @(posedge clk); #1;
    resp_ready[u] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      n_checks++;
      if (req_ready[u] !== 1'b1 || resp_valid[u] !== 1'b0 || resp_rdata[u] !== 32'h0 ||
          resp_err[u] !== 1'b0 || busy[u] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[u%0d]: got ready=%b valid=%b rdata=%h err=%b busy=%b, expected 1 0 00000000 0 0",
                 u, req_ready[u], resp_valid[u], resp_rdata[u], resp_err[u], busy[u]);
      end
    end
  endtask

  task automatic test_word_rw();
    logic [31:0] rd; logic er; int lat; exp_t e;
    logic        w [2] = '{1'b1, 1'b0};
    logic [31:0] d [2] = '{32'hDEADBEEF, 32'h0};
    logic [31:0] x [2] = '{32'h0, 32'hDEADBEEF};
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{x[i], 1'b0, 3});
      do_access(0, w[i], MODE_WORD, 32'h10, d[i], rd, er, lat);
      e = sb.pop_front();
      n_checks++;
      if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
        n_fail++;
        $display("FAIL word_rw[%0d]: got rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=%0d",
                 i, rd, er, lat, e.rdata, e.err, e.lat);
      end
      release_resp(0);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er; int lat; exp_t e;
    logic        w [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        m [5] = '{MODE_WORD, MODE_BYTE, MODE_WORD, MODE_BYTE, MODE_BYTE};
    logic [31:0] a [5] = '{32'h20, 32'h22, 32'h20, 32'h23, 32'h22};
    logic [31:0] d [5] = '{32'h11223344, 32'hFFFFFFAA, 32'h0, 32'h0, 32'h0};
    logic [31:0] x [5] = '{32'h0, 32'h0, 32'h11AA3344, 32'h00000011, 32'h000000AA};
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{x[i], 1'b0, 3});
      do_access(0, w[i], m[i], a[i], d[i], rd, er, lat);
      e = sb.pop_front();
      n_checks++;
      if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
        n_fail++;
        $display("FAIL byte_lanes[%0d]: got rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=%0d",
                 i, rd, er, lat, e.rdata, e.err, e.lat);
      end
      release_resp(0);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; exp_t e;
    sb.push_back('{32'hDEADBEEF, 1'b0, 3});
    do_access(0, 1'b0, MODE_WORD, 32'h10, 32'h0, rd, er, lat);
    e = sb.pop_front();
    n_checks++;
    if (rd !== e.rdata || lat != e.lat) begin
      n_fail++;
      $display("FAIL backpressure_resp: got rdata=%h lat=%0d, expected rdata=%h lat=%0d", rd, lat, e.rdata, e.lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== e.rdata || req_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got valid=%b rdata=%h ready=%b busy=%b, expected 1 %h 0 1",
                 c, resp_valid[0], resp_rdata[0], req_ready[0], busy[0], e.rdata);
      end
    end
    release_resp(0);
    n_checks++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: got valid=%b ready=%b busy=%b, expected 0 1 0",
               resp_valid[0], req_ready[0], busy[0]);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er; int lat; exp_t e;
    sb.push_back('{32'h0, 1'b0, 3});
    do_access(0, 1'b1, MODE_WORD, 32'h30, 32'h12345678, rd, er, lat);
    e = sb.pop_front();
    n_checks++;
    if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
      n_fail++;
      $display("FAIL rst_wait_setup: got rdata=%h err=%b lat=%0d, expected %h %b %0d", rd, er, lat, e.rdata, e.err, e.lat);
    end
    release_resp(0);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_mode[0] = MODE_WORD; req_addr[0] = 32'h30; req_wdata[0] = 32'h55;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n_checks++;
    if (busy[0] !== 1'b1 || req_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait_busy: got busy=%b ready=%b, expected 1 0", busy[0], req_ready[0]);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'h0 ||
        resp_err[0] !== 1'b0 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait_outputs: got ready=%b valid=%b rdata=%h err=%b busy=%b, expected 1 0 00000000 0 0",
               req_ready[0], resp_valid[0], resp_rdata[0], resp_err[0], busy[0]);
    end
    @(posedge clk); #1;
    n_checks++;
    if (resp_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait_no_resp: got valid=%b, expected 0", resp_valid[0]);
    end
    sb.push_back('{32'h12345678, 1'b0, 3});
    do_access(0, 1'b0, MODE_WORD, 32'h30, 32'h0, rd, er, lat);
    e = sb.pop_front();
    n_checks++;
    if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
      n_fail++;
      $display("FAIL rst_wait_reload: got rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=%0d",
               rd, er, lat, e.rdata, e.err, e.lat);
    end
    release_resp(0);
  endtask

  task automatic test_latency0();
    logic [31:0] rd; logic er; int lat; exp_t e;
    for (int i = 0; i < 16; i++) begin
      logic w;
      w = (i < 8);
      sb.push_back('{w ? 32'h0 : pat(i - 8), 1'b0, 1});
      do_access(1, w, MODE_WORD, 32'(4 * (i % 8)), pat(i), rd, er, lat);
      e = sb.pop_front();
      n_checks++;
      if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
        n_fail++;
        $display("FAIL lat0[%0d]: got rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=%0d",
                 i, rd, er, lat, e.rdata, e.err, e.lat);
      end
      release_resp(1);
    end
`ifdef DMEM_ALIGN_CHECK_EN
    sb.push_back('{32'h0, 1'b1, 1});
`else
    sb.push_back('{pat(0), 1'b0, 1});
`endif
    do_access(1, 1'b0, MODE_WORD, WRAP_ADDR, 32'h0, rd, er, lat);
    e = sb.pop_front();
    n_checks++;
    if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
      n_fail++;
      $display("FAIL lat0_wrap: got rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=%0d",
               rd, er, lat, e.rdata, e.err, e.lat);
    end
    release_resp(1);
  endtask

  task automatic test_align();
    logic [31:0] rd; logic er; int lat; exp_t e;
    logic        w [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] a [4] = '{32'h0, 32'h12, WRAP_ADDR, 32'h0};
    logic [31:0] d [4] = '{32'h0BADF00D, 32'h0, 32'hBAD0BAD0, 32'h0};
`ifdef DMEM_ALIGN_CHECK_EN
    logic [31:0] x [4] = '{32'h0, 32'h0, 32'h0, 32'h0BADF00D};
    logic        r [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
`else
    logic [31:0] x [4] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hBAD0BAD0};
    logic        r [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{x[i], r[i], 3});
      do_access(0, w[i], MODE_WORD, a[i], d[i], rd, er, lat);
      e = sb.pop_front();
      n_checks++;
      if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
        n_fail++;
        $display("FAIL align[%0d]: got rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=%0d",
                 i, rd, er, lat, e.rdata, e.err, e.lat);
      end
      release_resp(0);
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_write[u] = 1'b0; req_mode[u] = MODE_WORD;
      req_addr[u] = 32'h0; req_wdata[u] = 32'h0; resp_ready[u] = 1'b0;
    end
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_backpressure();
    test_reset_mid_wait();
    test_latency0();
    test_align();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
